// File: rtl/cpu_bus_pkg.sv
// Shared encodings and helpers for the tri-state bus register sequencer.
package cpu_bus_pkg;

    // Command opcodes
    localparam logic [1:0] OP_NOP      = 2'b00;
    localparam logic [1:0] OP_MOVE     = 2'b01;
    localparam logic [1:0] OP_LOAD_IMM = 2'b10;
    localparam logic [1:0] OP_READ     = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SETTLE = 2'b01;
    localparam logic [1:0] ST_WRITE  = 2'b10;

    // Opcodes that put a register (rather than the immediate) on the bus
    function automatic logic op_uses_src(input logic [1:0] op);
        return (op == OP_MOVE) || (op == OP_READ);
    endfunction

    // Opcodes that clock a destination register
    function automatic logic op_writes_dst(input logic [1:0] op);
        return (op == OP_MOVE) || (op == OP_LOAD_IMM);
    endfunction

    // True when a register index addresses an existing register
    function automatic logic index_in_range(input int index, input int count);
        return index < count;
    endfunction

endpackage

// File: rtl/reg_transfer_sequencer_onehot_decoder.sv
// Index to one-hot decoder; all zeros when not valid or index out of range.
module onehot_decoder #(
    parameter int SelBits  = 3,
    parameter int NrOfRegs = 8
) (
    input  logic [SelBits-1:0]  index,
    input  logic                valid,
    output logic [NrOfRegs-1:0] onehot
);

    // Set the single bit addressed by index
    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        onehot = '0;
        for (int i = 0; i < NrOfRegs; i++) begin
            if (valid && (int'(index) == i)) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Sequences cs / ClockEnable strobes for a bank of tri-state bus registers.
// One bus driver at most: either one register (cs low) or the immediate.
module reg_transfer_sequencer
    import cpu_bus_pkg::*;
#(
    parameter int NrOfBits = 8,
    parameter int NrOfRegs = 8,
    parameter int SelBits  = 3
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                Tick,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [SelBits-1:0]  cmd_src,
    input  logic [SelBits-1:0]  cmd_dst,
    input  logic [NrOfBits-1:0] cmd_imm,
    output logic [NrOfRegs-1:0] reg_cs,
    output logic [NrOfRegs-1:0] reg_ce,
    output logic [NrOfBits-1:0] bus_out,
    output logic                bus_oe,
    input  logic [NrOfBits-1:0] bus_in,
    output logic [NrOfBits-1:0] rd_data,
    output logic                done,
    output logic                err
);

    logic [1:0]          state;
    logic [1:0]          lat_op;
    logic [SelBits-1:0]  lat_dst;
    logic                accept;
    logic                cmd_legal;
    logic [NrOfRegs-1:0] src_onehot;
    logic [NrOfRegs-1:0] dst_onehot;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Legality of the offered command: distinct MOVE endpoints, indices in range
    always_comb begin
        cmd_legal = 1'b1;
        case (cmd_op)
            OP_MOVE:     cmd_legal = (cmd_src != cmd_dst)
                                     && index_in_range(int'(cmd_src), NrOfRegs)
                                     && index_in_range(int'(cmd_dst), NrOfRegs);
            OP_LOAD_IMM: cmd_legal = index_in_range(int'(cmd_dst), NrOfRegs);
            OP_READ:     cmd_legal = index_in_range(int'(cmd_src), NrOfRegs);
            default:     cmd_legal = 1'b1;
        endcase
    end

    // Source select for the cs strobes, decoded from the offered command
    onehot_decoder #(.SelBits(SelBits), .NrOfRegs(NrOfRegs)) u_src_dec (
        .index  (cmd_src),
        .valid  (accept && cmd_legal && op_uses_src(cmd_op)),
        .onehot (src_onehot)
    );

    // Destination select for the ClockEnable strobes, from the latched command
    onehot_decoder #(.SelBits(SelBits), .NrOfRegs(NrOfRegs)) u_dst_dec (
        .index  (lat_dst),
        .valid  (op_writes_dst(lat_op)),
        .onehot (dst_onehot)
    );

    // Command FSM and registered bus strobes
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_IDLE;
            lat_op  <= OP_NOP;
            lat_dst <= '0;
            reg_cs  <= '1;
            reg_ce  <= '0;
            bus_oe  <= 1'b0;
            bus_out <= '0;
            rd_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop reading pre-edge values.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_op  <= cmd_op;
                        lat_dst <= cmd_dst;
                        if (cmd_op == OP_NOP) begin
                            done <= 1'b1;
                        end else if (!cmd_legal) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            state  <= ST_SETTLE;
                            reg_cs <= ~src_onehot;
                            if (cmd_op == OP_LOAD_IMM) begin
                                bus_oe  <= 1'b1;
                                bus_out <= cmd_imm;
                            end
                        end
                    end
                end
                ST_SETTLE: begin
                    if (Tick) begin
                        state  <= ST_WRITE;
                        reg_ce <= dst_onehot;
                    end
                end
                ST_WRITE: begin
                    if (Tick) begin
                        state   <= ST_IDLE;
                        reg_cs  <= '1;
                        reg_ce  <= '0;
                        bus_oe  <= 1'b0;
                        bus_out <= '0;
                        done    <= 1'b1;
                        if (lat_op == OP_READ) begin
                            rd_data <= bus_in;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Bench for reg_transfer_sequencer: bus-register environment, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_reg_transfer_sequencer;

    localparam int NB = 8;
    localparam int NR = 8;
    localparam int SB = 3;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] MOVE = 2'b01;
    localparam logic [1:0] LOAD = 2'b10;
    localparam logic [1:0] READ = 2'b11;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          Tick;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [SB-1:0] cmd_src;
    logic [SB-1:0] cmd_dst;
    logic [NB-1:0] cmd_imm;
    logic [NR-1:0] reg_cs;
    logic [NR-1:0] reg_ce;
    logic [NB-1:0] bus_out;
    logic          bus_oe;
    logic [NB-1:0] bus_in;
    logic [NB-1:0] rd_data;
    logic          done;
    logic          err;

    // Second instance with six registers for out-of-range index checks
    logic          c6_valid;
    logic          c6_ready;
    logic [1:0]    c6_op;
    logic [2:0]    c6_src;
    logic [2:0]    c6_dst;
    logic [NB-1:0] c6_imm;
    logic [5:0]    c6_cs;
    logic [5:0]    c6_ce;
    logic [NB-1:0] c6_bus_out;
    logic          c6_oe;
    logic [NB-1:0] c6_rd;
    logic          c6_done;
    logic          c6_err;

    int checks   = 0;
    int failures = 0;
    int tick_period = 1;

    always #5 Clock = ~Clock;

    reg_transfer_sequencer #(.NrOfBits(NB), .NrOfRegs(NR), .SelBits(SB)) dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
        .reg_cs(reg_cs), .reg_ce(reg_ce), .bus_out(bus_out), .bus_oe(bus_oe),
        .bus_in(bus_in), .rd_data(rd_data), .done(done), .err(err)
    );

    reg_transfer_sequencer #(.NrOfBits(NB), .NrOfRegs(6), .SelBits(3)) dut6 (
        .Clock(Clock), .Reset(Reset), .Tick(Tick),
        .cmd_valid(c6_valid), .cmd_ready(c6_ready), .cmd_op(c6_op),
        .cmd_src(c6_src), .cmd_dst(c6_dst), .cmd_imm(c6_imm),
        .reg_cs(c6_cs), .reg_ce(c6_ce), .bus_out(c6_bus_out), .bus_oe(c6_oe),
        .bus_in(8'h00), .rd_data(c6_rd), .done(c6_done), .err(c6_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- bus register environment ----------------
    logic [NB-1:0] regs [NR];

    // Resolved bus: immediate driver, else the register whose cs is low
    always_comb begin
        bus_in = '0;
        if (bus_oe) begin
            bus_in = bus_out;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (!reg_cs[i]) bus_in = regs[i];
            end
        end
    end

    // Registers capture the bus on Tick edges while their ClockEnable is high
    always @(posedge Clock) begin
        if (Tick) begin
            for (int i = 0; i < NR; i++) begin
                if (reg_ce[i]) regs[i] <= bus_in;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic          m_active = 1'b0;
    int            m_ticks  = 0;
    logic [1:0]    m_op     = NOP;
    int            m_src    = 0;
    int            m_dst    = 0;
    logic [NB-1:0] m_imm    = '0;
    logic          m_done   = 1'b0;
    logic          m_err    = 1'b0;
    logic [NB-1:0] m_rd     = '0;
    logic [NB-1:0] m_regs [NR];
    int            accepts    = 0;
    int            dones_seen = 0;

    function automatic logic legal(input logic [1:0] op, input int src, input int dst, input int n);
        case (op)
            MOVE:    return (src != dst) && (src < n) && (dst < n);
            LOAD:    return dst < n;
            READ:    return src < n;
            default: return 1'b1;
        endcase
    endfunction

    // A command occupies the bus for two Tick edges after acceptance, then completes
    always @(posedge Clock) begin
        if (Reset) begin
            m_active <= 1'b0;
            m_ticks  <= 0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            m_rd     <= '0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_active) begin
                if (Tick) begin
                    if (m_ticks == 1) begin
                        m_active <= 1'b0;
                        m_done   <= 1'b1;
                        if (m_op == MOVE) m_regs[m_dst] <= m_regs[m_src];
                        if (m_op == LOAD) m_regs[m_dst] <= m_imm;
                        if (m_op == READ) m_rd <= m_regs[m_src];
                    end else begin
                        m_ticks <= m_ticks + 1;
                    end
                end
            end else if (cmd_valid) begin
                accepts <= accepts + 1;
                m_op    <= cmd_op;
                m_src   <= int'(cmd_src);
                m_dst   <= int'(cmd_dst);
                m_imm   <= cmd_imm;
                if (cmd_op == NOP) begin
                    m_done <= 1'b1;
                end else if (!legal(cmd_op, int'(cmd_src), int'(cmd_dst), NR)) begin
                    m_done <= 1'b1;
                    m_err  <= 1'b1;
                end else begin
                    m_active <= 1'b1;
                    m_ticks  <= 0;
                end
            end
        end
    end

    // Expected outputs derived from the model's transaction state
    logic [NR-1:0] e_cs;
    logic [NR-1:0] e_ce;
    logic          e_oe;
    logic [NB-1:0] e_bus_out;
    always_comb begin
        e_cs      = '1;
        e_ce      = '0;
        e_oe      = m_active && (m_op == LOAD);
        e_bus_out = e_oe ? m_imm : '0;
        if (m_active && (m_op == MOVE || m_op == READ)) e_cs[m_src] = 1'b0;
        if (m_active && m_ticks == 1 && (m_op == MOVE || m_op == LOAD)) e_ce[m_dst] = 1'b1;
    end

    // Per-cycle comparison and bus invariants
    always @(negedge Clock) begin
        if (!Reset) begin
            check("ready",   32'(cmd_ready), 32'(!m_active));
            check("reg_cs",  32'(reg_cs),    32'(e_cs));
            check("reg_ce",  32'(reg_ce),    32'(e_ce));
            check("bus_oe",  32'(bus_oe),    32'(e_oe));
            check("bus_out", 32'(bus_out),   32'(e_bus_out));
            check("done",    32'(done),      32'(m_done));
            check("err",     32'(err),       32'(m_err));
            check("rd_data", 32'(rd_data),   32'(m_rd));
            check("contention", 32'($countones(~reg_cs) + 32'(bus_oe) <= 1), 32'(1));
            check("ce_onehot0", 32'($onehot0(reg_ce)), 32'(1));
            if (done) dones_seen <= dones_seen + 1;
        end
    end

    // ---------------- Tick generator ----------------
    initial begin
        int cnt = 0;
        Tick = 1'b1;
        forever begin
            @(negedge Clock);
            cnt++;
            if (tick_period == 1)      Tick = 1'b1;
            else if (tick_period == 0) Tick = 1'($urandom_range(0, 1));
            else                       Tick = ((cnt % tick_period) == 0);
        end
    end

    // Present a command once ready; junk with valid high while not ready
    task automatic issue(input logic [1:0] op, input int src, input int dst, input logic [NB-1:0] imm);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_src   = 3'($urandom_range(0, 7));
            cmd_dst   = 3'($urandom_range(0, 7));
            cmd_imm   = 8'($urandom_range(0, 255));
            @(negedge Clock);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: ready stayed low for %0d cycles", n);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_src   = 3'(src);
        cmd_dst   = 3'(dst);
        cmd_imm   = imm;
        @(posedge Clock);
        @(negedge Clock);
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_src   = 3'($urandom_range(0, 7));
        cmd_dst   = 3'($urandom_range(0, 7));
    endtask

    // Bounded wait for done; returns with done visible at a negedge
    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s: done absent after %0d cycles", name, n);
        end
    endtask

    initial begin
        int n;
        int ce_cycles;
        int oe_bad;
        int acc0;
        int done0;

        Reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_imm   = '0;
        c6_valid  = 1'b0;
        c6_op     = NOP;
        c6_src    = '0;
        c6_dst    = '0;
        c6_imm    = '0;
        for (int i = 0; i < NR; i++) begin
            regs[i]   <= 8'(8'h10 + i);
            m_regs[i] <= 8'(8'h10 + i);
        end
        regs[2] <= 8'hA5;  m_regs[2] <= 8'hA5;
        regs[4] <= 8'h5A;  m_regs[4] <= 8'h5A;
        regs[5] <= 8'h00;  m_regs[5] <= 8'h00;

        // Reset values
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_cs",    32'(reg_cs),  32'h0000_00FF);
        check("rst_ce",    32'(reg_ce),  32'h0);
        check("rst_oe",    32'(bus_oe),  32'h0);
        check("rst_bus",   32'(bus_out), 32'h0);
        check("rst_rd",    32'(rd_data), 32'h0);
        check("rst_done",  32'(done),    32'h0);
        check("rst_err",   32'(err),     32'h0);
        check("rst_ready", 32'(cmd_ready), 32'h1);
        #2 Reset = 1'b0;

        // Reset asserted mid-WRITE of MOVE 2->5
        tick_period = 1;
        issue(MOVE, 2, 5, 8'h00);
        check("mr_cs1", 32'(reg_cs), 32'h0000_00FB);
        @(negedge Clock);
        check("mr_ce2", 32'(reg_ce), 32'h0000_0020);
        #2 Reset = 1'b1;
        #1;
        check("mr_async_cs", 32'(reg_cs), 32'h0000_00FF);
        check("mr_async_ce", 32'(reg_ce), 32'h0);
        @(posedge Clock);
        @(negedge Clock);
        #2 Reset = 1'b0;
        repeat (4) begin
            @(negedge Clock);
            check("mr_no_done", 32'(done), 32'h0);
            check("mr_ready",   32'(cmd_ready), 32'h1);
        end
        check("mr_r5_kept", 32'(regs[5]), 32'h0);

        // MOVE 2->5 with Tick tied high
        issue(MOVE, 2, 5, 8'h00);
        check("mv_c1_cs",   32'(reg_cs), 32'h0000_00FB);
        check("mv_c1_done", 32'(done),   32'h0);
        @(negedge Clock);
        check("mv_c2_ce",   32'(reg_ce), 32'h0000_0020);
        check("mv_c2_cs",   32'(reg_cs), 32'h0000_00FB);
        @(negedge Clock);
        check("mv_c3_cs",   32'(reg_cs), 32'h0000_00FF);
        check("mv_c3_ce",   32'(reg_ce), 32'h0);
        check("mv_c3_done", 32'(done),   32'h1);
        check("mv_r5",      32'(regs[5]), 32'h0000_00A5);

        // LOAD_IMM 8'h3C -> R7 with Tick every 4th cycle
        tick_period = 4;
        issue(LOAD, 0, 7, 8'h3C);
        n = 0; ce_cycles = 0; oe_bad = 0;
        while (!done && n < 64) begin
            if (bus_oe !== 1'b1 || bus_out !== 8'h3C) oe_bad++;
            if (reg_ce == 8'h80) ce_cycles++;
            @(negedge Clock);
            n++;
        end
        wait_done("ld_done");
        check("ld_oe_held",   32'(oe_bad),    32'h0);
        check("ld_ce_cycles", 32'(ce_cycles), 32'h4);
        check("ld_r7",        32'(regs[7]),   32'h0000_003C);

        // READ R4 (holds 8'h5A); no ClockEnable may appear
        issue(READ, 4, 0, 8'h00);
        n = 0; ce_cycles = 0;
        while (!done && n < 64) begin
            if (reg_ce != '0) ce_cycles++;
            @(negedge Clock);
            n++;
        end
        wait_done("rd_done");
        check("rd_value", 32'(rd_data),   32'h0000_005A);
        check("rd_no_ce", 32'(ce_cycles), 32'h0);
        issue(NOP, 0, 0, 8'h00);
        check("nop_done", 32'(done),    32'h1);
        check("rd_held",  32'(rd_data), 32'h0000_005A);
        @(negedge Clock);
        check("rd_held2", 32'(rd_data), 32'h0000_005A);

        // Illegal MOVE 3->3
        tick_period = 1;
        issue(MOVE, 3, 3, 8'h00);
        check("ill_done", 32'(done),   32'h1);
        check("ill_err",  32'(err),    32'h1);
        check("ill_cs",   32'(reg_cs), 32'h0000_00FF);
        check("ill_ce",   32'(reg_ce), 32'h0);

        // Six-register instance: LOAD_IMM to index 7 is out of range
        c6_valid = 1'b1;
        c6_op    = LOAD;
        c6_dst   = 3'd7;
        c6_imm   = 8'h99;
        @(posedge Clock);
        @(negedge Clock);
        c6_valid = 1'b0;
        check("r6_done", 32'(c6_done), 32'h1);
        check("r6_err",  32'(c6_err),  32'h1);
        check("r6_cs",   32'(c6_cs),   32'h0000_003F);
        check("r6_oe",   32'(c6_oe),   32'h0);
        @(negedge Clock);
        check("r6_ready", 32'(c6_ready), 32'h1);
        check("r6_pulse", 32'(c6_done),  32'h0);

        // Back-to-back random commands with random Tick
        tick_period = 0;
        acc0  = accepts;
        done0 = dones_seen;
        for (int k = 0; k < 40; k++) begin
            issue(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge Clock);
            n++;
        end
        repeat (3) @(negedge Clock);
        check("one_done_per_cmd", 32'(dones_seen - done0), 32'(accepts - acc0));
        for (int i = 0; i < NR; i++) begin
            check($sformatf("reg_file_%0d", i), 32'(regs[i]), 32'(m_regs[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop if the run wedges
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
